lanzones: RTL and testbench



---
 rtl/lanzones_pkg.sv | 55 +++++
 rtl/lanzones_alu.sv | 38 +++
 rtl/lanzones.sv | 158 +++++++++++++++
 tb/tb_lanzones.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lanzones_pkg.sv
// Shared encodings for the lanzones RV32I core: opcodes, funct3 codes, ALU ops, FSM states.
package lanzones_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [3:0] {
        AluAdd, AluSub, AluSll, AluSlt, AluSltu,
        AluXor, AluSrl, AluSra, AluOr, AluAnd
    } alu_op_e;

    typedef enum logic [1:0] {StIdle, StFetch, StExec} state_e;

    // alt selects SUB/SRA; callers decide when instruction bit 30 is meaningful.
    function automatic alu_op_e alu_op_from_f3(logic [2:0] f3, logic alt);
        alu_op_e op;
        case (f3)
            F3_ADD_SUB: op = alt ? AluSub : AluAdd;
            F3_SLL:     op = AluSll;
            F3_SLT:     op = AluSlt;
            F3_SLTU:    op = AluSltu;
            F3_XOR:     op = AluXor;
            F3_SR:      op = alt ? AluSra : AluSrl;
            F3_OR:      op = AluOr;
            default:    op = AluAnd;
        endcase
        return op;
    endfunction

    function automatic logic [31:0] align_word(logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/lanzones_alu.sv
// Combinational 32-bit ALU with equality and signed/unsigned less-than flags for branches.
module lanzones_alu
    import lanzones_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  alu_op_e     i_op,
    output logic [31:0] o_result,
    output logic        o_eq,
    output logic        o_lt,
    output logic        o_ltu
);

    logic [4:0] w_shamt;

    assign w_shamt = i_b[4:0];
    assign o_eq    = (i_a == i_b);
    assign o_lt    = ($signed(i_a) < $signed(i_b));
    assign o_ltu   = (i_a < i_b);

    always_comb begin
        o_result = '0;
        unique case (i_op)
            AluAdd:  o_result = i_a + i_b;
            AluSub:  o_result = i_a - i_b;
            AluSll:  o_result = i_a << w_shamt;
            AluSlt:  o_result = {31'b0, o_lt};
            AluSltu: o_result = {31'b0, o_ltu};
            AluXor:  o_result = i_a ^ i_b;
            AluSrl:  o_result = i_a >> w_shamt;
            AluSra:  o_result = 32'($signed(i_a) >>> w_shamt);
            AluOr:   o_result = i_a | i_b;
            AluAnd:  o_result = i_a & i_b;
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/lanzones.sv
// Multicycle RV32I core: fetch over a request/valid handshake, then execute in one cycle.
module lanzones
    import lanzones_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        RVld,
    input  logic [31:0] RData,
    output logic        RRdy,
    output logic [31:0] RAddr
);

    state_e      r_state, w_state_nxt;
    logic [31:0] r_pc, r_ir;
    logic [31:0] r_regs [32];

    logic [6:0]  w_opcode;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [2:0]  w_f3;
    logic        w_alt;
    logic [31:0] w_imm_i, w_imm_b, w_imm_u, w_imm_j;
    logic [31:0] w_rs1_val, w_rs2_val, w_pc_plus4;

    logic [31:0] w_alu_a, w_alu_b, w_alu_res;
    alu_op_e     w_alu_op;
    logic        w_eq, w_lt, w_ltu;

    logic        w_wr_en, w_taken;
    logic [31:0] w_wr_data, w_pc_nxt;

    assign w_opcode   = r_ir[6:0];
    assign w_rd       = r_ir[11:7];
    assign w_f3       = r_ir[14:12];
    assign w_rs1      = r_ir[19:15];
    assign w_rs2      = r_ir[24:20];
    assign w_alt      = r_ir[30];
    assign w_imm_i    = {{20{r_ir[31]}}, r_ir[31:20]};
    assign w_imm_b    = {{20{r_ir[31]}}, r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
    assign w_imm_u    = {r_ir[31:12], 12'b0};
    assign w_imm_j    = {{12{r_ir[31]}}, r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
    assign w_rs1_val  = r_regs[w_rs1];
    assign w_rs2_val  = r_regs[w_rs2];
    assign w_pc_plus4 = r_pc + 32'd4;

    assign RAddr = r_pc;

    lanzones_alu u_alu (
        .i_a      (w_alu_a),
        .i_b      (w_alu_b),
        .i_op     (w_alu_op),
        .o_result (w_alu_res),
        .o_eq     (w_eq),
        .o_lt     (w_lt),
        .o_ltu    (w_ltu)
    );

    always_comb begin
        w_alu_a   = w_rs1_val;
        w_alu_b   = w_rs2_val;
        w_alu_op  = AluAdd;
        w_wr_en   = 1'b0;
        w_wr_data = w_alu_res;
        w_taken   = 1'b0;
        w_pc_nxt  = w_pc_plus4;
        case (w_opcode)
            OP_LUI: begin
                w_wr_en   = 1'b1;
                w_wr_data = w_imm_u;
            end
            OP_AUIPC: begin
                w_alu_a = r_pc;
                w_alu_b = w_imm_u;
                w_wr_en = 1'b1;
            end
            OP_JAL: begin
                w_wr_en   = 1'b1;
                w_wr_data = w_pc_plus4;
                w_pc_nxt  = r_pc + w_imm_j;
            end
            OP_JALR: begin
                // Target uses the pre-write rs1, so rd==rs1 behaves correctly.
                w_wr_en   = 1'b1;
                w_wr_data = w_pc_plus4;
                w_pc_nxt  = w_rs1_val + w_imm_i;
            end
            OP_BRANCH: begin
                case (w_f3)
                    F3_BEQ:  w_taken = w_eq;
                    F3_BNE:  w_taken = !w_eq;
                    F3_BLT:  w_taken = w_lt;
                    F3_BGE:  w_taken = !w_lt;
                    F3_BLTU: w_taken = w_ltu;
                    F3_BGEU: w_taken = !w_ltu;
                    default: w_taken = 1'b0;
                endcase
                if (w_taken) begin
                    w_pc_nxt = r_pc + w_imm_b;
                end
            end
            OP_IMM: begin
                // Bit 30 is part of the immediate except on right shifts.
                w_alu_b  = w_imm_i;
                w_alu_op = alu_op_from_f3(w_f3, w_alt && (w_f3 == F3_SR));
                w_wr_en  = 1'b1;
            end
            OP_OP: begin
                w_alu_op = alu_op_from_f3(w_f3, w_alt);
                w_wr_en  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        RRdy        = 1'b0;
        unique case (r_state)
            StIdle:  w_state_nxt = StFetch;
            StFetch: begin
                RRdy = 1'b1;
                if (RVld) begin
                    w_state_nxt = StExec;
                end
            end
            StExec:  w_state_nxt = StFetch;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= StIdle;
            r_pc    <= RESET_ADDR;
            r_ir    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == StFetch && RVld) begin
                r_ir <= RData;
            end
            if (r_state == StExec) begin
                r_pc <= align_word(w_pc_nxt);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (r_state == StExec && w_wr_en && w_rd != 5'd0) begin
            r_regs[w_rd] <= w_wr_data;
        end
    end

endmodule

// File: tb/tb_lanzones.sv
// Bench for lanzones: directed fetch/branch/reset steps then random programs against an ISA model.
module tb_lanzones;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        RVld = 1'b0;
    logic [31:0] RData = '0;
    logic        RRdy;
    logic [31:0] RAddr;

    lanzones #(.RESET_ADDR(32'h0000_0000)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .RVld  (RVld),
        .RData (RData),
        .RRdy  (RRdy),
        .RAddr (RAddr)
    );

    always #5 clk = ~clk;

    typedef enum logic [4:0] {
        KLui, KAuipc, KJal, KJalr, KBeq, KBne, KBlt, KBge, KBltu, KBgeu,
        KAddi, KSlti, KSltiu, KXori, KOri, KAndi, KSlli, KSrli, KSrai,
        KAdd, KSub, KSll, KSlt, KSltu, KXor, KOr, KAnd, KSrl, KSra, KNop
    } kind_e;

    typedef struct {
        kind_e       kind;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } op_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_x [32];
    logic [31:0] m_pc;
    logic [6:0]  nop_opc [5] = '{7'h03, 7'h23, 7'h0F, 7'h73, 7'h5B};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_pc = 32'h0;
        for (int i = 0; i < 32; i++) m_x[i] = 32'h0;
    endtask

    function automatic op_t mk(kind_e k, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                               logic [31:0] imm);
        op_t op;
        op.kind = k; op.rd = rd; op.rs1 = rs1; op.rs2 = rs2; op.imm = imm;
        return op;
    endfunction

    task automatic model_exec(input op_t op);
        logic [31:0] a, b, nxt, val;
        logic        wr, take;
        a = m_x[op.rs1]; b = m_x[op.rs2];
        nxt = m_pc + 4; val = 0; wr = 1'b1; take = 1'b0;
        case (op.kind)
            KLui:   val = op.imm;
            KAuipc: val = m_pc + op.imm;
            KJal:   begin val = m_pc + 4; nxt = m_pc + op.imm; end
            KJalr:  begin val = m_pc + 4; nxt = a + op.imm; end
            KBeq:   begin wr = 1'b0; take = (a == b); end
            KBne:   begin wr = 1'b0; take = (a != b); end
            KBlt:   begin wr = 1'b0; take = ($signed(a) < $signed(b)); end
            KBge:   begin wr = 1'b0; take = ($signed(a) >= $signed(b)); end
            KBltu:  begin wr = 1'b0; take = (a < b); end
            KBgeu:  begin wr = 1'b0; take = (a >= b); end
            KAddi:  val = a + op.imm;
            KSlti:  val = ($signed(a) < $signed(op.imm)) ? 32'd1 : 32'd0;
            KSltiu: val = (a < op.imm) ? 32'd1 : 32'd0;
            KXori:  val = a ^ op.imm;
            KOri:   val = a | op.imm;
            KAndi:  val = a & op.imm;
            KSlli:  val = a << op.imm[4:0];
            KSrli:  val = a >> op.imm[4:0];
            KSrai:  val = 32'($signed(a) >>> op.imm[4:0]);
            KAdd:   val = a + b;
            KSub:   val = a - b;
            KSll:   val = a << b[4:0];
            KSlt:   val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            KSltu:  val = (a < b) ? 32'd1 : 32'd0;
            KXor:   val = a ^ b;
            KOr:    val = a | b;
            KAnd:   val = a & b;
            KSrl:   val = a >> b[4:0];
            KSra:   val = 32'($signed(a) >>> b[4:0]);
            default: wr = 1'b0;
        endcase
        if (take) nxt = m_pc + op.imm;
        if (wr && op.rd != 5'd0) m_x[op.rd] = val;
        m_pc = nxt & 32'hFFFF_FFFC;
    endtask

    function automatic logic [31:0] enc_b(op_t op, logic [2:0] f3);
        logic [31:0] m;
        m = op.imm;
        return {m[12], m[10:5], op.rs2, op.rs1, f3, m[4:1], m[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_i(op_t op, logic [2:0] f3);
        logic [31:0] m;
        m = op.imm;
        return {m[11:0], op.rs1, f3, op.rd, 7'h13};
    endfunction

    function automatic logic [31:0] enc_sh(op_t op, logic [6:0] f7, logic [2:0] f3);
        logic [31:0] m;
        m = op.imm;
        return {f7, m[4:0], op.rs1, f3, op.rd, 7'h13};
    endfunction

    function automatic logic [31:0] enc_r(op_t op, logic [6:0] f7, logic [2:0] f3);
        return {f7, op.rs2, op.rs1, f3, op.rd, 7'h33};
    endfunction

    function automatic logic [31:0] encode(op_t op);
        logic [31:0] m;
        m = op.imm;
        case (op.kind)
            KLui:   return {m[31:12], op.rd, 7'h37};
            KAuipc: return {m[31:12], op.rd, 7'h17};
            KJal:   return {m[20], m[10:1], m[11], m[19:12], op.rd, 7'h6F};
            KJalr:  return {m[11:0], op.rs1, 3'b000, op.rd, 7'h67};
            KBeq:   return enc_b(op, 3'b000);
            KBne:   return enc_b(op, 3'b001);
            KBlt:   return enc_b(op, 3'b100);
            KBge:   return enc_b(op, 3'b101);
            KBltu:  return enc_b(op, 3'b110);
            KBgeu:  return enc_b(op, 3'b111);
            KAddi:  return enc_i(op, 3'b000);
            KSlti:  return enc_i(op, 3'b010);
            KSltiu: return enc_i(op, 3'b011);
            KXori:  return enc_i(op, 3'b100);
            KOri:   return enc_i(op, 3'b110);
            KAndi:  return enc_i(op, 3'b111);
            KSlli:  return enc_sh(op, 7'h00, 3'b001);
            KSrli:  return enc_sh(op, 7'h00, 3'b101);
            KSrai:  return enc_sh(op, 7'h20, 3'b101);
            KAdd:   return enc_r(op, 7'h00, 3'b000);
            KSub:   return enc_r(op, 7'h20, 3'b000);
            KSll:   return enc_r(op, 7'h00, 3'b001);
            KSlt:   return enc_r(op, 7'h00, 3'b010);
            KSltu:  return enc_r(op, 7'h00, 3'b011);
            KXor:   return enc_r(op, 7'h00, 3'b100);
            KOr:    return enc_r(op, 7'h00, 3'b110);
            KAnd:   return enc_r(op, 7'h00, 3'b111);
            KSrl:   return enc_r(op, 7'h00, 3'b101);
            KSra:   return enc_r(op, 7'h20, 3'b101);
            default: return m;
        endcase
    endfunction

    function automatic op_t rand_op();
        op_t         op;
        logic [31:0] r;
        r       = $urandom;
        op.kind = kind_e'(5'($urandom_range(0, 29)));
        op.rd   = 5'($urandom_range(0, 7));
        op.rs1  = 5'($urandom_range(0, 7));
        op.rs2  = 5'($urandom_range(0, 7));
        case (op.kind)
            KLui, KAuipc:               op.imm = {r[31:12], 12'h0};
            KJal:                       op.imm = {{11{r[20]}}, r[20:1], 1'b0};
            KBeq, KBne, KBlt, KBge, KBltu, KBgeu:
                                        op.imm = {{19{r[12]}}, r[12:1], 1'b0};
            KSlli, KSrli, KSrai:        op.imm = {27'h0, r[4:0]};
            KNop:                       op.imm = {r[31:7], nop_opc[$urandom_range(0, 4)]};
            default:                    op.imm = {{20{r[11]}}, r[11:0]};
        endcase
        return op;
    endfunction

    // One fetch + execute: optional stall, transfer, random RVld/RData noise during EXEC.
    task automatic fetch(input logic [31:0] word, input op_t op, input int stall);
        check("fetch_rrdy", {31'b0, RRdy}, 32'd1);
        check("fetch_addr", RAddr, m_pc);
        for (int i = 0; i < stall; i++) begin
            RVld = 1'b0;
            RData = $urandom;
            tick();
            check("stall_rrdy", {31'b0, RRdy}, 32'd1);
            check("stall_addr", RAddr, m_pc);
        end
        RVld = 1'b1;
        RData = word;
        tick();
        check("exec_rrdy", {31'b0, RRdy}, 32'd0);
        RVld = 1'($urandom);
        RData = $urandom;
        tick();
        RVld = 1'b0;
        model_exec(op);
    endtask

    initial begin
        op_t op;
        model_reset();
        rstn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_rrdy", {31'b0, RRdy}, 32'd0);
            check("rst_addr", RAddr, 32'h0);
        end
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("idle_rrdy", {31'b0, RRdy}, 32'd0);
        tick();

        fetch(32'h0000_0013, mk(KAddi, 0, 0, 0, 0), 5);
        check("nop_next", RAddr, 32'h4);
        fetch(32'h1000_0093, mk(KAddi, 1, 0, 0, 32'h100), 0);
        fetch(32'h0000_8067, mk(KJalr, 0, 1, 0, 0), 0);
        check("jalr_x1", RAddr, 32'h100);
        fetch(32'h0400_0013, mk(KAddi, 0, 0, 0, 32'h40), 0);
        fetch(32'h0000_0067, mk(KJalr, 0, 0, 0, 0), 0);
        check("jalr_x0", RAddr, 32'h0);
        fetch(32'h0100_00EF, mk(KJal, 1, 0, 0, 32'h10), 0);
        check("jal_tgt", RAddr, 32'h10);
        fetch(32'h0000_8067, mk(KJalr, 0, 1, 0, 0), 1);
        check("jal_link", RAddr, 32'h4);
        fetch(32'h0000_0067, mk(KJalr, 0, 0, 0, 0), 0);
        fetch(32'h0000_1463, mk(KBne, 0, 0, 0, 32'h8), 0);
        check("bne_nt", RAddr, 32'h4);
        fetch(32'h0000_0463, mk(KBeq, 0, 0, 0, 32'h8), 2);
        check("beq_t", RAddr, 32'hC);

        for (int n = 0; n < 400; n++) begin
            op = rand_op();
            fetch(encode(op), op, $urandom_range(0, 2));
        end
        check("rand_final_addr", RAddr, m_pc);

        fetch(32'h1000_0067, mk(KJalr, 0, 0, 0, 32'h100), 0);
        check("pre_rst_addr", RAddr, 32'h100);
        RVld = 1'b1;
        RData = 32'h1000_0093;
        tick();
        RVld = 1'b0;
        check("mid_exec_rrdy", {31'b0, RRdy}, 32'd0);
        #2;
        rstn = 1'b0;
        #1;
        check("async_rst_rrdy", {31'b0, RRdy}, 32'd0);
        check("async_rst_addr", RAddr, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
        tick();
        fetch(32'h0000_8067, mk(KJalr, 0, 1, 0, 0), 0);
        check("post_rst_x1", RAddr, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
